div_sequencer: RTL and testbench

Multi-cycle controller and datapath for the integer divide/remainder group of the M extension (DIV, DIVU, REM, REMU and their W forms).
- Accepts an operation code from the ALU decoder's 5-bit control space, runs a radix-2 restoring division, and applies sign and special-case fixup.
- Sits beside the single-cycle ALU in the execute stage. The execute stage stalls on o_busy.

---
 rtl/div_sequencer_pkg.sv | 23 ++
 rtl/div_sequencer_datapath.sv | 85 ++++++++
 rtl/div_sequencer.sv | 156 +++++++++++++++
 tb/tb_div_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the integer divide/remainder sequencer:
// ALU control codes for the divide group, FSM state type, W iteration count.
package div_sequencer_pkg;

   localparam logic [4:0] ALU_DIV   = 5'b10011;
   localparam logic [4:0] ALU_DIVU  = 5'b10100;
   localparam logic [4:0] ALU_REM   = 5'b10101;
   localparam logic [4:0] ALU_REMU  = 5'b10110;
   localparam logic [4:0] ALU_DIVW  = 5'b11000;
   localparam logic [4:0] ALU_DIVUW = 5'b11001;
   localparam logic [4:0] ALU_REMW  = 5'b11010;
   localparam logic [4:0] ALU_REMUW = 5'b11011;

   localparam int W_ITER = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_sequencer_datapath.sv
// Radix-2 restoring divider datapath: remainder/quotient shift registers,
// trial subtractor, sign fixup and W-result sign extension.
// Magnitudes arrive pre-computed; W dividends arrive left-aligned so that
// 32 steps leave the quotient in the low half of quo_q.
module div_datapath #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            step_i,
   input  logic            fixup_i,
   input  logic            special_i,
   input  logic [XLEN-1:0] dvd_i,
   input  logic [XLEN-1:0] dvs_i,
   input  logic [XLEN-1:0] special_val_i,
   input  logic            special_w_i,
   input  logic            neg_quo_i,
   input  logic            neg_rem_i,
   input  logic            sel_rem_i,
   input  logic            is_w_i,
   output logic [XLEN-1:0] result_o
);

   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] res_q, res_d;
   logic [XLEN:0]   trial;
   logic [XLEN-1:0] quo_fin, rem_fin, sel_fin;

   function automatic logic [XLEN-1:0] w_ext(input logic [XLEN-1:0] v, input logic w);
      return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   // borrow out of the top bit means the divisor does not fit: restore
   assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

   // next-state for the shift registers and result register
   always_comb begin
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      quo_fin = neg_quo_i ? -quo_q : quo_q;
      rem_fin = neg_rem_i ? -rem_q : rem_q;
      sel_fin = sel_rem_i ? rem_fin : quo_fin;
      if (load_i) begin
         quo_d = dvd_i;
         rem_d = '0;
         dvs_d = dvs_i;
      end else if (step_i) begin
         if (trial[XLEN]) begin
            rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_d = {quo_q[XLEN-2:0], 1'b0};
         end else begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
         end
      end
      if (special_i) begin
         res_d = w_ext(special_val_i, special_w_i);
      end else if (fixup_i) begin
         res_d = w_ext(sel_fin, is_w_i);
      end
   end

   // register update
   always_ff @(posedge clk) begin
      if (rst) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         res_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         res_q <= res_d;
      end
   end

   assign result_o = res_q;

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle divide/remainder sequencer for DIV/DIVU/REM/REMU and W forms.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
//
// state | meaning
// IDLE  | waiting for a valid divide start
// CALC  | one shift-subtract step per cycle, counter counts down
// FIXUP | apply signs, pick quotient or remainder, W sign-extend
// DONE  | o_done pulse, result register valid
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic [4:0]      i_alu_control,
   input  logic [XLEN-1:0] i_src_1,
   input  logic [XLEN-1:0] i_src_2,
   input  logic            i_flush,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CNT_W = $clog2(XLEN + 1);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;
   logic             neg_quo_q, neg_rem_q, sel_rem_q, is_w_q;

   logic             op_valid, op_signed, op_rem, op_w;
   logic [XLEN-1:0]  op1, op2, mag1, mag2, min_val, special_val, dvd_load;
   logic             neg1, neg2, div_zero, ovf, early;
   logic             accept, take_special, load, step, fixup;

   // decode the incoming op and detect special cases
   always_comb begin
      op_valid  = 1'b1;
      op_signed = 1'b0;
      op_rem    = 1'b0;
      op_w      = 1'b0;
      case (i_alu_control)
         ALU_DIV:   op_signed = 1'b1;
         ALU_DIVU:  ;
         ALU_REM:   begin op_signed = 1'b1; op_rem = 1'b1; end
         ALU_REMU:  op_rem = 1'b1;
         ALU_DIVW:  begin op_signed = 1'b1; op_w = 1'b1; end
         ALU_DIVUW: op_w = 1'b1;
         ALU_REMW:  begin op_signed = 1'b1; op_rem = 1'b1; op_w = 1'b1; end
         ALU_REMUW: begin op_rem = 1'b1; op_w = 1'b1; end
         default:   op_valid = 1'b0;
      endcase
      op1 = op_w ? {{(XLEN-32){op_signed & i_src_1[31]}}, i_src_1[31:0]} : i_src_1;
      op2 = op_w ? {{(XLEN-32){op_signed & i_src_2[31]}}, i_src_2[31:0]} : i_src_2;
      neg1 = op_signed & op1[XLEN-1];
      neg2 = op_signed & op2[XLEN-1];
      mag1 = neg1 ? -op1 : op1;
      mag2 = neg2 ? -op2 : op2;
      min_val = op_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = (op2 == '0);
      ovf      = op_signed & (op1 == min_val) & (&op2);
`ifdef DIV_EARLY_OUT_EN
      early    = (mag1 < mag2);
`else
      early    = 1'b0;
`endif
      if (div_zero)
         special_val = op_rem ? op1 : '1;
      else if (ovf)
         special_val = op_rem ? '0 : op1;
      else
         special_val = op_rem ? op1 : '0;
      dvd_load = op_w ? {mag1[31:0], {(XLEN-32){1'b0}}} : mag1;

      accept       = (state_q == S_IDLE) & i_start & op_valid & ~i_flush;
      take_special = accept & (div_zero | ovf | early);
      load         = accept & ~take_special;
      step         = (state_q == S_CALC) & ~i_flush;
      fixup        = (state_q == S_FIXUP) & ~i_flush;
   end

   // sequencing FSM with iteration counter and latched op attributes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         sel_rem_q <= 1'b0;
         is_w_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  neg_quo_q <= neg1 ^ neg2;
                  neg_rem_q <= neg1;
                  sel_rem_q <= op_rem;
                  is_w_q    <= op_w;
                  if (take_special) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_CALC;
                     cnt_q   <= op_w ? CNT_W'(W_ITER) : CNT_W'(XLEN);
                  end
               end
            end
            S_CALC: begin
               if (i_flush) begin
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1))
                     state_q <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               if (i_flush) begin
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   div_datapath #(.XLEN(XLEN)) u_dp (
      .clk           (clk),
      .rst           (rst),
      .load_i        (load),
      .step_i        (step),
      .fixup_i       (fixup),
      .special_i     (take_special),
      .dvd_i         (dvd_load),
      .dvs_i         (mag2),
      .special_val_i (special_val),
      .special_w_i   (op_w),
      .neg_quo_i     (neg_quo_q),
      .neg_rem_i     (neg_rem_q),
      .sel_rem_i     (sel_rem_q),
      .is_w_i        (is_w_q),
      .result_o      (o_result)
   );

   assign o_busy = (state_q != S_IDLE);
   assign o_done = done_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: arithmetic reference model plus
// per-cycle check of o_busy/o_done/o_result, and literal expectations.
module tb_div_sequencer;

   localparam logic [4:0] C_DIV   = 5'b10011;
   localparam logic [4:0] C_DIVU  = 5'b10100;
   localparam logic [4:0] C_REM   = 5'b10101;
   localparam logic [4:0] C_REMU  = 5'b10110;
   localparam logic [4:0] C_DIVW  = 5'b11000;
   localparam logic [4:0] C_DIVUW = 5'b11001;
   localparam logic [4:0] C_REMW  = 5'b11010;
   localparam logic [4:0] C_REMUW = 5'b11011;
   localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_flush = 1'b0;
   logic [4:0]  i_alu_control = 5'd0;
   logic [63:0] i_src_1 = 64'd0;
   logic [63:0] i_src_2 = 64'd0;
   logic        o_busy, o_done;
   logic [63:0] o_result;

   div_sequencer #(.XLEN(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_alu_control (i_alu_control),
      .i_src_1       (i_src_1),
      .i_src_2       (i_src_2),
      .i_flush       (i_flush),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_result      (o_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_pass = 0;
   int          n_tot = 0;
   int          exp_start = 0;
   int          exp_end = 0;
   bit          done_en = 1'b0;
   bit          chk_en = 1'b0;
   bit          got_done = 1'b0;
   logic [63:0] exp_val = 64'd0;
   logic [63:0] got_val = 64'd0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tot++;
      if (got === want) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, got, want);
   endtask

   function automatic bit is_w(input logic [4:0] op);
      return (op == C_DIVW) || (op == C_DIVUW) || (op == C_REMW) || (op == C_REMUW);
   endfunction

   function automatic bit is_signed_op(input logic [4:0] op);
      return (op == C_DIV) || (op == C_REM) || (op == C_DIVW) || (op == C_REMW);
   endfunction

   function automatic logic [63:0] model_res(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32, b32, r32;
      logic signed [63:0] sa, sb;
      logic signed [31:0] sa32, sb32;
      logic [63:0] r;
      bool_ovf: begin end
      a32 = a[31:0]; b32 = b[31:0];
      sa = a; sb = b; sa32 = a32; sb32 = b32;
      r = 64'd0; r32 = 32'd0;
      case (op)
         C_DIVU:  if (b == 0) r = '1; else r = a / b;
         C_REMU:  if (b == 0) r = a;  else r = a % b;
         C_DIV:   if (b == 0) r = '1; else if (a == MIN64 && b == '1) r = a; else r = sa / sb;
         C_REM:   if (b == 0) r = a;  else if (a == MIN64 && b == '1) r = 0; else r = sa % sb;
         C_DIVUW: if (b32 == 0) r32 = '1;  else r32 = a32 / b32;
         C_REMUW: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
         C_DIVW:  if (b32 == 0) r32 = '1;  else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32; else r32 = sa32 / sb32;
         C_REMW:  if (b32 == 0) r32 = a32; else if (a32 == 32'h8000_0000 && b32 == '1) r32 = 0; else r32 = sa32 % sb32;
         default: r = 64'd0;
      endcase
      if (is_w(op)) r = {{32{r32[31]}}, r32};
      return r;
   endfunction

   // cycles from start to the o_done pulse; 0 for codes that are not accepted
   function automatic int model_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
      bit sg, dz, ov, early;
      logic [63:0] ma, mb;
      logic [31:0] ma32, mb32;
      case (op)
         C_DIV, C_DIVU, C_REM, C_REMU, C_DIVW, C_DIVUW, C_REMW, C_REMUW: ;
         default: return 0;
      endcase
      sg = is_signed_op(op);
      if (is_w(op)) begin
         dz = (b[31:0] == 0);
         ov = sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
         ma32 = (sg && a[31]) ? -a[31:0] : a[31:0];
         mb32 = (sg && b[31]) ? -b[31:0] : b[31:0];
         early = ma32 < mb32;
      end else begin
         dz = (b == 0);
         ov = sg && a == MIN64 && b == '1;
         ma = (sg && a[63]) ? -a : a;
         mb = (sg && b[63]) ? -b : b;
         early = ma < mb;
      end
`ifndef DIV_EARLY_OUT_EN
      early = 1'b0;
`endif
      if (dz || ov || early) return 1;
      return is_w(op) ? 34 : 66;
   endfunction

   // per-cycle compare against the expected busy window and done cycle
   always @(negedge clk) begin
      bit eb, ed;
      if (chk_en) begin
         eb = (cyc > exp_start) && (cyc <= exp_end);
         ed = done_en && (cyc == exp_end);
         chk("busy", {63'd0, o_busy}, {63'd0, eb});
         chk("done", {63'd0, o_done}, {63'd0, ed});
         if (ed && o_done) begin
            chk("result", o_result, exp_val);
            got_done = 1'b1;
            got_val  = o_result;
         end
      end
   end

   // start an op in the current cycle; flush/rst/extra-start at given offsets (-1 = none)
   task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input int flush_at, input int rst_at, input int busy_at);
      int c, lat, k;
      exp_val  = model_res(op, a, b);
      lat      = model_lat(op, a, b);
      c        = cyc;
      got_done = 1'b0;
      exp_start = c;
      exp_end   = c + lat;
      done_en   = (lat > 0);
      i_alu_control = op; i_src_1 = a; i_src_2 = b; i_start = 1'b1;
      for (k = 0; k < 200; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            i_start = 1'b0; i_flush = 1'b0; rst = 1'b0;
         end
         if (k == flush_at) begin
            i_flush = 1'b1;
            if (k < lat) begin exp_end = c + k; done_en = 1'b0; end
         end
         if (k == rst_at) begin
            rst = 1'b1; exp_end = c + k; done_en = 1'b0;
         end
         if (k == busy_at) begin
            i_start = 1'b1; i_alu_control = C_DIVU; i_src_1 = 64'd77; i_src_2 = 64'd1;
         end
         if (cyc > exp_end) break;
      end
      chk("op_bounded", {63'd0, (cyc > exp_end)}, 64'd1);
      if (done_en) chk("done_seen", {63'd0, got_done}, 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {63'd0, o_busy}, 64'd0);
      chk("reset_done", {63'd0, o_done}, 64'd0);
      chk("reset_result", o_result, 64'd0);
      rst = 1'b0;
      exp_start = cyc; exp_end = cyc;
      chk_en = 1'b1;
      @(posedge clk); #1;

      run_op(C_DIVU, 64'd100, 64'd7, -1, -1, -1);
      chk("lit_divu_100_7", got_val, 64'd14);
      run_op(C_REMU, 64'd100, 64'd7, -1, -1, 5);
      chk("lit_remu_100_7", got_val, 64'd2);
      run_op(C_DIV, -64'sd7, 64'd2, -1, -1, -1);
      chk("lit_div_m7_2", got_val, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(C_REM, -64'sd7, 64'd2, -1, -1, -1);
      chk("lit_rem_m7_2", got_val, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op(C_REM, 64'd7, -64'sd2, -1, -1, -1);
      chk("lit_rem_7_m2", got_val, 64'd1);
      run_op(C_DIV, 64'd5, 64'd0, 1, -1, -1);
      chk("lit_div_by0", got_val, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op(C_REMU, 64'd5, 64'd0, -1, -1, -1);
      chk("lit_remu_by0", got_val, 64'd5);
      run_op(C_DIV, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1, -1);
      chk("lit_div_ovf", got_val, MIN64);
      run_op(C_REMW, 64'h8000_0000, 64'hFFFF_FFFF, -1, -1, -1);
      chk("lit_remw_ovf", got_val, 64'd0);
      run_op(C_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, -1, -1, -1);
      chk("lit_divuw", got_val, 64'h0000_0000_7FFF_FFFF);
      run_op(C_DIVW, 64'h8000_0000, 64'd2, -1, -1, -1);
      chk("lit_divw", got_val, 64'hFFFF_FFFF_C000_0000);

      run_op(C_DIVU, 64'd1000, 64'd3, 10, -1, -1);
      chk("hold_after_flush_calc", o_result, 64'hFFFF_FFFF_C000_0000);
      @(posedge clk); #1;
      run_op(C_DIVU, 64'd9, 64'd3, -1, -1, -1);
      chk("lit_divu_9_3", got_val, 64'd3);
      run_op(C_DIVU, 64'd1000, 64'd7, 65, -1, -1);
      chk("hold_after_flush_fixup", o_result, 64'd3);

      run_op(5'b00000, 64'd10, 64'd2, -1, -1, -1);
      run_op(C_DIVU, 64'd7, 64'd3, 0, -1, -1);

      run_op(C_DIV, -64'sd100, -64'sd7, -1, -1, -1);
      chk("lit_div_m100_m7", got_val, 64'd14);
      run_op(C_REM, MIN64, 64'd3, -1, -1, -1);
      run_op(C_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, -1, -1, -1);
      chk("lit_divu_big", got_val, 64'd1);
      run_op(C_REMU, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, -1, -1, -1);
      chk("lit_remu_big", got_val, 64'h7FFF_FFFF_FFFF_FFFF);
      run_op(C_REMUW, 64'h1_FFFF_FFFF, 64'h10, -1, -1, -1);
      chk("lit_remuw", got_val, 64'hF);
      run_op(C_DIVUW, 64'hFFFF_FFFF, 64'd1, -1, -1, -1);
      chk("lit_divuw_ext", got_val, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op(C_REMW, 64'hFFFF_FFF9, 64'd2, -1, -1, -1);
      chk("lit_remw_m7_2", got_val, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op(C_DIVU, 64'd3, 64'd100, -1, -1, -1);
      chk("lit_divu_small", got_val, 64'd0);

      run_op(C_DIVU, 64'd50, 64'd5, -1, 5, -1);
      chk("rst_mid_busy", {63'd0, o_busy}, 64'd0);
      chk("rst_mid_done", {63'd0, o_done}, 64'd0);
      chk("rst_mid_result", o_result, 64'd0);
      run_op(C_REMU, 64'd23, 64'd5, -1, -1, -1);
      chk("lit_after_rst", got_val, 64'd3);

      chk_en = 1'b0;
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
